calc_seq_p: RTL
===============

Name: calc_seq_p

Overview:
- Parametrised successor of the team's single-accumulator decimal calculator.
- Accepts one 4-bit keypad command per valid/ready handshake and builds decimal operands digit by digit.
- Computes add, subtract and multiply (multiply by iterative shift-add), with optional divide.
- After every accepted command it serialises the current value, least-significant digit (LSD) first, to the 7-seg display driver as (data, pos, data_valid) beats.
- Chaining: an operator pressed while a result is shown uses that result as operand A.

Parameters:
- NDIG, 8: number of decimal display digits; legal range 1..16; the maximum value is 10^NDIG-1.
- WIDTH, 27: operand/result register width; must satisfy 2^WIDTH > 10^NDIG-1.
- MUL_CYC, WIDTH: iterations of the shift-add multiplier; fixed at WIDTH.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- cmd  in  4  0-9 digit; 10 add; 11 sub; 12 mul; 13 div; 14 equals; 15 backspace.
- cmd_valid  in  1  cmd is presented.
- cmd_ready  out  1  block can accept a command; equals (status==READY).
- status  out  2  00 ERROR, 01 BUSY, 10 READY; 11 is never driven.
- data  out  4  BCD digit being presented.
- pos  out  4  digit index of data; 0 is the LSD.
- data_valid  out  1  data/pos are valid this cycle.
- state  out  3  current FSM state, for debug.

Behaviour:
- Clock/reset (already decided): reset reset, asynchronous, active-high; clock clock.
- Reset values: state=ENTRY_A, status=READY, A=B=acc=0, op=0, data=0, pos=0, data_valid=0. Reset mid-operation (multiply, scan or error) aborts immediately to these values.
- Accept rule: a command is taken on an edge where cmd_valid && cmd_ready. status is BUSY from the following cycle until the display scan completes.
- Scan: on NDIG consecutive edges, data = decimal digit pos of the shown value, for pos = 0..NDIG-1, with data_valid=1. Leading zeros are sent as 0. data_valid=0 on the edge after pos=NDIG-1, and on that same edge status returns to READY.
- Latency: for non-compute commands, the first scan beat appears 1 cycle after acceptance and cmd_ready returns NDIG+1 cycles after acceptance.
- States: ENTRY_A, OPSEL, ENTRY_B, COMPUTE, SHOW, ERROR.
- ENTRY_A:
  - digit d: acc = acc*10+d. If acc already holds NDIG digits (acc ≥ 10^(NDIG-1)), the command is accepted and ignored, but still rescanned.
  - 15: acc = acc/10.
  - 10-13: A=acc, op=cmd, acc=0, go to OPSEL.
  - 14: no change.
- OPSEL:
  - operator: replaces op.
  - digit: acc=d, go to ENTRY_B.
  - 15 or 14: no change.
- ENTRY_B:
  - digit or 15: same rules as ENTRY_A.
  - 14: B=acc, go to COMPUTE.
  - 10-13: go to ERROR.
- COMPUTE:
  - add and sub: 1 cycle.
  - mul: MUL_CYC cycles, using a 2*WIDTH-bit partial product.
  - Result goes to acc, then the scan runs and the state becomes SHOW.
- Result errors (go to ERROR instead of scanning): sub result negative (A<B); any result > 10^NDIG-1.
- SHOW:
  - digit d: acc=d, go to ENTRY_A (new calculation).
  - operator: A=acc, op=cmd, acc=0, go to OPSEL (chaining).
  - 15: acc=acc/10, go to ENTRY_A.
  - 14: no change.
- ERROR: status=ERROR, cmd_ready=0, no scan beats. The state is sticky; only reset leaves it.
- Arithmetic is unsigned binary throughout. Binary-to-BCD conversion for the scan uses a per-beat %10 and /10 on a WIDTH-bit shadow copy of the shown value.

Optional Feature:
- Macro CALC_DIV_EN.
- Defined: op 13 performs restoring division acc=A/B (quotient only) in WIDTH cycles. B==0 goes to ERROR.
- Undefined: cmd 13 accepted in ENTRY_A, OPSEL, ENTRY_B or SHOW goes to ERROR. No divider logic is synthesised.

Decomposition:
- Shared package calc_pkg contains:
  - state enum calc_state_t;
  - status constants ST_ERR, ST_BUSY, ST_READY;
  - command constants CMD_ADD=10, CMD_SUB=11, CMD_MUL=12, CMD_DIV=13, CMD_EQ=14, CMD_BS=15.
- One sub-module, calc_bcd_scan: loads a value and emits NDIG (data, pos, data_valid) beats, then pulses done.

Test Plan:
- Reset, then 1,2,3 → each scan ends with acc=123; last scan beats are pos0=3, pos1=2, pos2=1, pos3..7=0; cmd_ready low for exactly 9 cycles per command.
- 4,5,add,1,7,eq → 62 shown; then sub,2,eq → 60 (chaining from SHOW).
- 9,9,9,9,mul,1,0,0,0,0,eq → 99990000 shown after WIDTH compute cycles plus 8 scan beats. A follow-up mul,1,0,eq → ERROR (overflow); status=00; no further beats until reset.
- 5,sub,7,eq → ERROR. Then assert reset for 1 cycle mid-error → status=10, acc=0, state=ENTRY_A.
- 1,2,3,bs,bs,bs,bs → acc sequence 12,1,0,0. Then 9 digits of 9 → acc saturates at 99999999 and the 9th digit is ignored.
- With CALC_DIV_EN: 8,4,div,4,eq → 21; 8,div,0,eq → ERROR. Without the macro: 8,div → ERROR.

Source files
------------

// File: rtl/calc_pkg.sv
// calc_pkg: shared types and constants for the calc_seq_p calculator.
// Holds the FSM state enum, status codes, keypad commands and a pow10 helper.
package calc_pkg;

    typedef enum logic [2:0] {
        S_ENTRY_A = 3'd0,
        S_OPSEL   = 3'd1,
        S_ENTRY_B = 3'd2,
        S_COMPUTE = 3'd3,
        S_SHOW    = 3'd4,
        S_ERROR   = 3'd5
    } calc_state_t;

    localparam logic [1:0] ST_ERR   = 2'b00;
    localparam logic [1:0] ST_BUSY  = 2'b01;
    localparam logic [1:0] ST_READY = 2'b10;

    localparam logic [3:0] CMD_ADD = 4'd10;
    localparam logic [3:0] CMD_SUB = 4'd11;
    localparam logic [3:0] CMD_MUL = 4'd12;
    localparam logic [3:0] CMD_DIV = 4'd13;
    localparam logic [3:0] CMD_EQ  = 4'd14;
    localparam logic [3:0] CMD_BS  = 4'd15;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) p = p * 64'd10;
        return p;
    endfunction

endpackage

// File: rtl/calc_seq_p_if.sv
// calc_seq_p_if: keypad command handshake plus display/status bundle.
// master = keypad/display side, slave = calculator.
interface calc_seq_p_if;
    logic [3:0] cmd;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] status;
    logic [3:0] data;
    logic [3:0] pos;
    logic       data_valid;
    logic [2:0] state;

    modport master (
        output cmd, cmd_valid,
        input  cmd_ready, status, data, pos, data_valid, state
    );

    modport slave (
        input  cmd, cmd_valid,
        output cmd_ready, status, data, pos, data_valid, state
    );
endinterface

// File: rtl/calc_bcd_scan.sv
// calc_bcd_scan: loads a binary value and emits NDIG BCD beats, LSD first.
// done is high in the cycle after the last beat, while data_valid drops.
module calc_bcd_scan #(
    parameter int NDIG  = 8,
    parameter int WIDTH = 27
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    output logic [3:0]       data,
    output logic [3:0]       pos,
    output logic             data_valid,
    output logic             done
);
    localparam int CW = $clog2(NDIG + 1);

    logic [WIDTH-1:0] shadow;
    logic [CW-1:0]    cnt;
    logic             active;

    assign done = active && (cnt == CW'(NDIG));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shadow     <= '0;
            cnt        <= '0;
            active     <= 1'b0;
            data       <= '0;
            pos        <= '0;
            data_valid <= 1'b0;
        end else if (load) begin
            shadow     <= value;
            cnt        <= '0;
            active     <= 1'b1;
            data_valid <= 1'b0;
        end else if (done) begin
            active     <= 1'b0;
            data_valid <= 1'b0;
        end else if (active) begin
            data       <= 4'(shadow % WIDTH'(10));
            pos        <= 4'(cnt);
            data_valid <= 1'b1;
            shadow     <= shadow / WIDTH'(10);
            cnt        <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/calc_seq_p.sv
// calc_seq_p: keypad-driven decimal calculator with shift-add multiply.
// Define CALC_DIV_EN to build the restoring divider for command 13.
module calc_seq_p
    import calc_pkg::*;
#(
    parameter int NDIG    = 8,
    parameter int WIDTH   = 27,
    parameter int MUL_CYC = WIDTH
) (
    input  logic        clock,
    input  logic        reset,
    calc_seq_p_if.slave bus
);
    localparam logic [WIDTH-1:0] MAXV = WIDTH'(pow10(NDIG) - 64'd1);
    localparam logic [WIDTH-1:0] FULL = WIDTH'(pow10(NDIG - 1));
    localparam int CW = $clog2(MUL_CYC + 1);

    calc_state_t        st, c_st;
    logic [1:0]         status;
    logic [WIDTH-1:0]   a, b, acc, c_acc;
    logic [3:0]         op;
    logic [2*WIDTH-1:0] prod, mcand, pnext;
    logic [WIDTH-1:0]   mpl;
    logic [CW-1:0]      ccnt;
    logic               take, is_dig, is_op, op_bad, div0;
    logic               c_lda, c_ldop, c_ldb, c_err;
    logic               r_done, r_err, scan_ld, scan_done;
    logic [WIDTH-1:0]   dval, shift_in, acc_bs, r_val, scan_val;
    logic [WIDTH:0]     sum;

    assign take      = bus.cmd_valid && bus.cmd_ready;
    assign is_dig    = bus.cmd <= 4'd9;
    assign is_op     = bus.cmd >= CMD_ADD && bus.cmd <= CMD_DIV;
    assign dval      = WIDTH'(bus.cmd);
    assign shift_in  = (acc >= FULL) ? acc : (acc << 3) + (acc << 1) + dval;
    assign acc_bs    = acc / WIDTH'(10);
    assign sum       = {1'b0, a} + {1'b0, b};
    assign pnext     = prod + (mpl[0] ? mcand : '0);

`ifdef CALC_DIV_EN
    logic [WIDTH-1:0] rem, quo, qnext, rnext;
    logic [WIDTH:0]   rsh;

    assign op_bad = 1'b0;
    assign div0   = (op == CMD_DIV) && (acc == '0);
    assign rsh    = {rem, quo[WIDTH-1]};

    always_comb begin
        qnext = {quo[WIDTH-2:0], 1'b0};
        rnext = rsh[WIDTH-1:0];
        if (rsh >= {1'b0, b}) begin
            qnext = {quo[WIDTH-2:0], 1'b1};
            rnext = WIDTH'(rsh - {1'b0, b});
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rem <= '0;
            quo <= '0;
        end else if (take && c_ldb) begin
            rem <= '0;
            quo <= a;
        end else if (st == S_COMPUTE) begin
            rem <= rnext;
            quo <= qnext;
        end
    end
`else
    assign op_bad = bus.cmd == CMD_DIV;
    assign div0   = 1'b0;
`endif

    // Command decode: what an accepted keypress does in each state.
    always_comb begin
        c_st   = st;
        c_acc  = acc;
        c_lda  = 1'b0;
        c_ldop = 1'b0;
        c_ldb  = 1'b0;
        c_err  = 1'b0;
        unique case (st)
            S_ENTRY_A, S_ENTRY_B: begin
                unique case (1'b1)
                    is_dig:            c_acc = shift_in;
                    bus.cmd == CMD_BS: c_acc = acc_bs;
                    bus.cmd == CMD_EQ: begin
                        if (st == S_ENTRY_B) begin
                            c_ldb = 1'b1;
                            c_st  = S_COMPUTE;
                            c_err = div0;
                        end
                    end
                    default: begin
                        if (st == S_ENTRY_B || op_bad) begin
                            c_err = 1'b1;
                        end else begin
                            c_lda  = 1'b1;
                            c_ldop = 1'b1;
                            c_acc  = '0;
                            c_st   = S_OPSEL;
                        end
                    end
                endcase
            end
            S_OPSEL: begin
                unique case (1'b1)
                    is_dig: begin
                        c_acc = dval;
                        c_st  = S_ENTRY_B;
                    end
                    is_op: begin
                        c_ldop = 1'b1;
                        c_err  = op_bad;
                    end
                    default: ;
                endcase
            end
            S_SHOW: begin
                unique case (1'b1)
                    is_dig: begin
                        c_acc = dval;
                        c_st  = S_ENTRY_A;
                    end
                    is_op: begin
                        c_err  = op_bad;
                        c_lda  = 1'b1;
                        c_ldop = 1'b1;
                        c_acc  = '0;
                        c_st   = S_OPSEL;
                    end
                    bus.cmd == CMD_BS: begin
                        c_acc = acc_bs;
                        c_st  = S_ENTRY_A;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    always_comb begin
        r_done = 1'b0;
        r_err  = 1'b0;
        r_val  = '0;
        if (st == S_COMPUTE) begin
            unique case (1'b1)
                op == CMD_ADD: begin
                    r_done = 1'b1;
                    r_err  = sum > {1'b0, MAXV};
                    r_val  = sum[WIDTH-1:0];
                end
                op == CMD_SUB: begin
                    r_done = 1'b1;
                    r_err  = a < b;
                    r_val  = a - b;
                end
                op == CMD_MUL: begin
                    r_done = ccnt == CW'(MUL_CYC - 1);
                    r_err  = pnext > {{WIDTH{1'b0}}, MAXV};
                    r_val  = pnext[WIDTH-1:0];
                end
`ifdef CALC_DIV_EN
                op == CMD_DIV: begin
                    r_done = ccnt == CW'(WIDTH - 1);
                    r_val  = qnext;
                end
`endif
                default: ;
            endcase
        end
    end

    assign scan_ld  = (take && !c_err && c_st != S_COMPUTE) || (r_done && !r_err);
    assign scan_val = take ? c_acc : r_val;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            st     <= S_ENTRY_A;
            status <= ST_READY;
            a      <= '0;
            b      <= '0;
            acc    <= '0;
            op     <= '0;
            prod   <= '0;
            mcand  <= '0;
            mpl    <= '0;
            ccnt   <= '0;
        end else if (take) begin
            st     <= c_err ? S_ERROR : c_st;
            status <= c_err ? ST_ERR : ST_BUSY;
            acc    <= c_acc;
            if (c_lda) a <= acc;
            if (c_ldop) op <= bus.cmd;
            if (c_ldb) begin
                b     <= acc;
                mpl   <= acc;
                mcand <= {{WIDTH{1'b0}}, a};
                prod  <= '0;
                ccnt  <= '0;
            end
        end else if (r_done) begin
            st     <= r_err ? S_ERROR : S_SHOW;
            status <= r_err ? ST_ERR : ST_BUSY;
            if (!r_err) acc <= r_val;
        end else if (st == S_COMPUTE) begin
            prod  <= pnext;
            mcand <= mcand << 1;
            mpl   <= mpl >> 1;
            ccnt  <= ccnt + 1'b1;
        end else if (scan_done) begin
            status <= ST_READY;
        end
    end

    calc_bcd_scan #(
        .NDIG (NDIG),
        .WIDTH(WIDTH)
    ) u_scan (
        .clock     (clock),
        .reset     (reset),
        .load      (scan_ld),
        .value     (scan_val),
        .data      (bus.data),
        .pos       (bus.pos),
        .data_valid(bus.data_valid),
        .done      (scan_done)
    );

    assign bus.status    = status;
    assign bus.cmd_ready = status == ST_READY;
    assign bus.state     = st;
endmodule
